egress_frame_reader: RTL and testbench
======================================

Name: egress_frame_reader

Overview:
- Drain stage directly downstream of the ingress frame buffer.
- Pops one sideband descriptor per frame (length plus drop flag), then reads that frame's 16-bit half-words out of the 20-bit-wide frame FIFO.
- Kept frames are emitted on an AXI-stream egress with tlast; dropped frames are consumed silently.
- Absorbs the FIFO's 1-cycle read latency with a 2-entry output skid buffer, so it sustains 1 word/cycle under backpressure.

Parameters:
- LEN_WIDTH, 11: width of the frame length field in half-words; max frame 2^LEN_WIDTH-1 words.
- W_EL, 20: frame FIFO memory word width; data is bits [15:0].

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-high reset
- en  input  1  enable; gates start of new frames only
- sb_empty  input  1  sideband FIFO empty
- sb_ren  output  1  sideband FIFO pop
- sb_rdata  input  LEN_WIDTH+1  {drop, len}; valid 1 cycle after sb_ren
- frame_empty  input  1  frame FIFO empty
- frame_ren  output  1  frame FIFO pop
- frame_rdata  input  W_EL  frame word; valid 1 cycle after frame_ren
- egress_tdata  output  16  stream data
- egress_tvalid  output  1  stream valid
- egress_tlast  output  1  last word of frame
- egress_tready  input  1  downstream ready
- busy  output  1  high in any state other than IDLE

Behaviour:
- Reset is asynchronous, active-high. While asserted:
  - all outputs are 0;
  - FSM is in IDLE, skid buffer is empty, remaining-word counter is 0, in-flight flag is cleared.
- A reset asserted mid-frame abandons the frame. The remaining words stay in the FIFO; the owner resets the FIFO pointers.
- FSM states and transitions:
  - IDLE: if en & !sb_empty, assert sb_ren for 1 cycle and go to DESC.
  - DESC: capture sb_rdata, loading rem = len and drop_q = drop.
    - If len == 0: back to IDLE; no frame reads, no output.
    - Else if drop: go to DROP.
    - Else: go to STREAM.
  - STREAM: frame_ren = !frame_empty & (rem != 0) & (occ - pop + inflight < 2).
    - occ = skid entries (0..2); pop = egress_tvalid & egress_tready; inflight = frame_ren issued last cycle.
    - Each frame_ren decrements rem.
    - The returning word is written to the skid buffer the next cycle. Its tlast is set if rem was 1 when that read was issued.
    - When rem == 0, inflight == 0 and the tlast word is accepted (tvalid & tready): go to IDLE.
  - DROP: frame_ren = !frame_empty & (rem != 0), with no skid gating. Returned data is discarded. When rem == 0 and inflight == 0: go to IDLE.
- Handshake rules:
  - AXI-stream rules apply: once tvalid is high, tdata/tlast are held stable until tready.
  - tvalid never depends combinationally on tready.
  - Outputs are driven from the skid head register.
- Latency and throughput:
  - Sideband pop to first egress_tvalid is 3 cycles when frame_empty is low.
  - Steady state is 1 word/cycle with tready high.
  - A new descriptor is popped no earlier than the cycle after the previous tlast handshake. There is a 3-cycle inter-frame gap.
- Boundary conditions:
  - frame_empty mid-frame: stall reads and keep rem; resume when not empty. No words are invented or lost.
  - egress_tready low: at most 2 words are buffered, then reads stop. No overflow.
  - en deasserted mid-frame: the current frame or drop completes; no new descriptor is popped.
  - sb_empty with en high: remain in IDLE.
  - len == 2^LEN_WIDTH-1: handled; rem is LEN_WIDTH bits and never wraps below 0.
  - frame_rdata[W_EL-1:16] is ignored.

Optional Feature:
- Macro: EGRESS_FRAME_STATS_EN.
- Defined: adds outputs frames_sent[15:0] and frames_dropped[15:0].
  - frames_sent increments on each tlast handshake.
  - frames_dropped increments on each DROP→IDLE and on each len==0 descriptor.
  - Both saturate at 16'hFFFF and clear on reset.
- Undefined: ports and logic are absent; core behaviour is identical.

Test Plan:
- Descriptor {0,4}, FIFO holds A,B,C,D, tready=1: four beats A,B,C,D on consecutive cycles, tlast only on D; first tvalid 3 cycles after sb_ren; busy falls after D.
- Descriptor {1,3} then {0,2}: 3 FIFO pops with no egress for the first frame; second frame emits 2 beats with tlast on the 2nd. With stats enabled, sent=1, dropped=1.
- 6-word frame, tready toggles 1,0,0,1,0,1,...: all 6 words delivered in order with none lost; frame_ren is never issued while occ+inflight would exceed 2; tdata is stable while stalled.
- frame_empty held high for 5 cycles after the 2nd word of an 8-word frame: output stalls, then resumes with words 3..8; tlast on word 8.
- Descriptor {0,0}: no frame_ren, no tvalid; FSM returns to IDLE in 2 cycles.
- Reset asserted during the 3rd beat of a 5-beat frame: tvalid, tlast, busy, sb_ren and frame_ren go to 0 immediately (asynchronously); after release, the FSM is in IDLE and waits for the next descriptor.

Source files
------------

// File: rtl/egress_frame_reader.sv
// egress_frame_reader: descriptor-driven drain of the frame FIFO onto AXI-stream; EGRESS_FRAME_STATS_EN adds frame counters
module egress_frame_reader #(
    parameter int LEN_WIDTH = 11,
    parameter int W_EL      = 20
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 en,
    input  logic                 sb_empty,
    output logic                 sb_ren,
    input  logic [LEN_WIDTH:0]   sb_rdata,
    input  logic                 frame_empty,
    output logic                 frame_ren,
    input  logic [W_EL-1:0]      frame_rdata,
    output logic [15:0]          egress_tdata,
    output logic                 egress_tvalid,
    output logic                 egress_tlast,
    input  logic                 egress_tready,
`ifdef EGRESS_FRAME_STATS_EN
    output logic [15:0]          frames_sent,
    output logic [15:0]          frames_dropped,
`endif
    output logic                 busy
);
    typedef enum logic [1:0] {IDLE, DESC, STREAM, DROP} state_t;
    state_t state, state_n;
    logic [LEN_WIDTH-1:0] rem, cur_rem, len;
    logic drop, inflight, inflight_last, pop, wr;
    logic h_valid, h_last, t_valid, t_last;
    logic [15:0] h_data, t_data;
    logic [2:0] lvl;
    logic unused_hi;
    assign unused_hi = ^frame_rdata[W_EL-1:16];
    assign len = sb_rdata[LEN_WIDTH-1:0];
    assign drop = sb_rdata[LEN_WIDTH];
    assign pop = h_valid & egress_tready;
    assign wr = inflight & (state == STREAM);
    assign lvl = 3'(h_valid) + 3'(t_valid) + 3'(inflight);
    assign cur_rem = (state == DESC) ? len : rem;
    assign busy = (state != IDLE);
    assign egress_tdata = h_data;
    assign egress_tvalid = h_valid;
    assign egress_tlast = h_last;
    // The first read is issued straight from DESC (skid is empty there) to hit the 3-cycle pop-to-valid latency
    always_comb begin
        state_n = state;
        sb_ren = 1'b0;
        frame_ren = 1'b0;
        case (state)
            IDLE: begin
                sb_ren = en & !sb_empty & !reset;
                state_n = (en & !sb_empty) ? DESC : IDLE;
            end
            DESC: begin
                frame_ren = !frame_empty & (len != '0);
                state_n = (len == '0) ? IDLE : drop ? DROP : STREAM;
            end
            STREAM: begin
                frame_ren = !frame_empty & (rem != '0) & (lvl < 3'd2 + 3'(pop));
                state_n = ((rem == '0) & !inflight & pop & h_last) ? IDLE : STREAM;
            end
            DROP: begin
                frame_ren = !frame_empty & (rem != '0);
                state_n = ((rem == '0) & !inflight) ? IDLE : DROP;
            end
            default: state_n = IDLE;
        endcase
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            rem <= '0;
            inflight <= 1'b0;
            inflight_last <= 1'b0;
        end else begin
            state <= state_n;
            rem <= cur_rem - LEN_WIDTH'(frame_ren);
            inflight <= frame_ren;
            inflight_last <= frame_ren & (cur_rem == LEN_WIDTH'(1));
        end
    end
    // Two-entry skid: head drives the stream, tail catches the word already in flight when the head stalls
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            h_valid <= 1'b0;
            h_last <= 1'b0;
            h_data <= '0;
            t_valid <= 1'b0;
            t_last <= 1'b0;
            t_data <= '0;
        end else if (pop | !h_valid) begin
            h_valid <= t_valid | wr;
            h_data <= t_valid ? t_data : frame_rdata[15:0];
            h_last <= t_valid ? t_last : inflight_last;
            t_valid <= t_valid & wr;
            t_data <= frame_rdata[15:0];
            t_last <= inflight_last;
        end else if (wr) begin
            t_valid <= 1'b1;
            t_data <= frame_rdata[15:0];
            t_last <= inflight_last;
        end
    end
`ifdef EGRESS_FRAME_STATS_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            frames_sent <= '0;
            frames_dropped <= '0;
        end else begin
            if (pop & h_last & (frames_sent != 16'hFFFF))
                frames_sent <= frames_sent + 16'd1;
            if ((((state == DROP) & (state_n == IDLE)) | ((state == DESC) & (len == '0))) & (frames_dropped != 16'hFFFF))
                frames_dropped <= frames_dropped + 16'd1;
        end
    end
`endif
endmodule

// File: tb/tb_egress_frame_reader.sv
// tb_egress_frame_reader: directed scenarios against behavioural sideband/frame FIFOs with 1-cycle read latency
module tb_egress_frame_reader;
    localparam int LW = 11;
    localparam int WE = 20;
    logic clk = 1'b0;
    logic reset, en, sb_empty, sb_ren, frame_empty, frame_ren;
    logic egress_tvalid, egress_tlast, egress_tready, busy;
    logic [LW:0] sb_rdata;
    logic [WE-1:0] frame_rdata;
    logic [15:0] egress_tdata;
`ifdef EGRESS_FRAME_STATS_EN
    logic [15:0] frames_sent, frames_dropped;
`endif
    int checks = 0;
    int failures = 0;
    logic [LW:0] sb_mem [64];
    logic [WE-1:0] fr_mem [128];
    int sb_wr = 0, sb_rd = 0, fr_wr = 0, fr_rd = 0;
    logic fifo_clr = 1'b0;
    int cyc = 0, rx_n = 0, nreads = 0, sb_cyc = 0, busy_fall = 0;
    int out_cnt = 0, ovf_err = 0, stab_err = 0;
    logic track = 1'b0, prev_stall = 1'b0, prev_busy = 1'b0, prev_last = 1'b0;
    logic [15:0] prev_data = '0;
    logic [15:0] rx_data [64];
    logic rx_last [64];
    int rx_cyc [64];

    egress_frame_reader #(.LEN_WIDTH(LW), .W_EL(WE)) dut (
        .clk(clk), .reset(reset), .en(en),
        .sb_empty(sb_empty), .sb_ren(sb_ren), .sb_rdata(sb_rdata),
        .frame_empty(frame_empty), .frame_ren(frame_ren), .frame_rdata(frame_rdata),
        .egress_tdata(egress_tdata), .egress_tvalid(egress_tvalid),
        .egress_tlast(egress_tlast), .egress_tready(egress_tready),
`ifdef EGRESS_FRAME_STATS_EN
        .frames_sent(frames_sent), .frames_dropped(frames_dropped),
`endif
        .busy(busy)
    );

    always #5 clk = ~clk;
    assign sb_empty = (sb_wr == sb_rd);
    assign frame_empty = (fr_wr == fr_rd);

    always @(posedge clk) begin
        if (fifo_clr) fr_rd <= fr_wr;
        else if (frame_ren) begin
            frame_rdata <= fr_mem[fr_rd];
            fr_rd <= fr_rd + 1;
        end
        if (sb_ren) begin
            sb_rdata <= sb_mem[sb_rd];
            sb_rd <= sb_rd + 1;
        end
    end

    always @(negedge clk) begin
        if (egress_tvalid && egress_tready) begin
            rx_data[rx_n] <= egress_tdata;
            rx_last[rx_n] <= egress_tlast;
            rx_cyc[rx_n] <= cyc;
            rx_n <= rx_n + 1;
        end
        if (frame_ren) nreads <= nreads + 1;
        if (sb_ren) sb_cyc <= cyc;
        if (prev_busy && !busy) busy_fall <= cyc;
        prev_busy <= busy;
        if (!track) out_cnt <= 0;
        else begin
            if (out_cnt + int'(frame_ren) - int'(egress_tvalid && egress_tready) > 2) ovf_err <= ovf_err + 1;
            out_cnt <= out_cnt + int'(frame_ren) - int'(egress_tvalid && egress_tready);
        end
        if (!reset && prev_stall && (egress_tvalid !== 1'b1 || egress_tdata !== prev_data || egress_tlast !== prev_last))
            stab_err <= stab_err + 1;
        prev_stall <= egress_tvalid && !egress_tready && !reset;
        prev_data <= egress_tdata;
        prev_last <= egress_tlast;
        cyc <= cyc + 1;
    end

    task automatic push_word(input logic [15:0] d);
        fr_mem[fr_wr] = {4'hC, d};
        fr_wr++;
    endtask

    task automatic push_desc(input logic d, input int len);
        sb_mem[sb_wr] = {d, LW'(len)};
        sb_wr++;
    endtask

    task automatic wait_rx(input int target, input int bound, input string name);
        for (int i = 0; i < bound && rx_n < target; i++) @(posedge clk);
        #1;
        checks++;
        if (rx_n < target) begin
            failures++;
            $display("FAIL %s_timeout beats=%0d required=%0d", name, rx_n, target);
        end
    endtask

    task automatic test_reset;
        en = 1'b0;
        egress_tready = 1'b1;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({egress_tvalid, egress_tlast, egress_tdata, busy, sb_ren, frame_ren} !== 21'd0) begin
            failures++;
            $display("FAIL reset_outputs got=%h required=0", {egress_tvalid, egress_tlast, egress_tdata, busy, sb_ren, frame_ren});
        end
        en = 1'b1;
        reset = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (busy !== 1'b0 || sb_ren !== 1'b0) begin
            failures++;
            $display("FAIL idle_sb_empty busy=%b sb_ren=%b required=0,0", busy, sb_ren);
        end
    endtask

    task automatic test_basic;
        logic [15:0] e [4] = '{16'hA001, 16'hB002, 16'hC003, 16'hD004};
        int b = rx_n;
        for (int i = 0; i < 4; i++) push_word(e[i]);
        push_desc(1'b0, 4);
        wait_rx(b + 4, 40, "basic");
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (rx_data[b+i] !== e[i] || rx_last[b+i] !== (i == 3)) begin
                failures++;
                $display("FAIL basic_beat%0d got=%h/%b required=%h/%b", i, rx_data[b+i], rx_last[b+i], e[i], i == 3);
            end
        end
        checks++;
        if (rx_cyc[b] - sb_cyc !== 3) begin
            failures++;
            $display("FAIL basic_latency got=%0d required=3", rx_cyc[b] - sb_cyc);
        end
        checks++;
        if (rx_cyc[b+3] - rx_cyc[b] !== 3) begin
            failures++;
            $display("FAIL basic_throughput span=%0d required=3", rx_cyc[b+3] - rx_cyc[b]);
        end
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (busy_fall !== rx_cyc[b+3] + 1) begin
            failures++;
            $display("FAIL basic_busy_fall got=%0d required=%0d", busy_fall, rx_cyc[b+3] + 1);
        end
    endtask

    task automatic test_drop;
        int b = rx_n;
        int r0 = nreads;
`ifdef EGRESS_FRAME_STATS_EN
        logic [15:0] s0 = frames_sent;
        logic [15:0] d0 = frames_dropped;
`endif
        push_word(16'h1111); push_word(16'h2222); push_word(16'h3333);
        push_word(16'h4444); push_word(16'h5555);
        push_desc(1'b1, 3);
        push_desc(1'b0, 2);
        wait_rx(b + 2, 60, "drop");
        checks++;
        if (rx_data[b] !== 16'h4444 || rx_last[b] !== 1'b0) begin
            failures++;
            $display("FAIL drop_beat0 got=%h/%b required=4444/0", rx_data[b], rx_last[b]);
        end
        checks++;
        if (rx_data[b+1] !== 16'h5555 || rx_last[b+1] !== 1'b1) begin
            failures++;
            $display("FAIL drop_beat1 got=%h/%b required=5555/1", rx_data[b+1], rx_last[b+1]);
        end
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (nreads - r0 !== 5 || rx_n !== b + 2) begin
            failures++;
            $display("FAIL drop_counts reads=%0d beats=%0d required=5,2", nreads - r0, rx_n - b);
        end
`ifdef EGRESS_FRAME_STATS_EN
        checks++;
        if (frames_sent - s0 !== 16'd1 || frames_dropped - d0 !== 16'd1) begin
            failures++;
            $display("FAIL drop_stats sent=%0d dropped=%0d required=1,1", frames_sent - s0, frames_dropped - d0);
        end
`endif
    endtask

    task automatic test_backpressure;
        logic [5:0] pat = 6'b101001;
        int b = rx_n;
        int o0 = ovf_err;
        int s0 = stab_err;
        track = 1'b1;
        for (int i = 0; i < 6; i++) push_word(16'h6000 + 16'(i));
        push_desc(1'b0, 6);
        for (int i = 0; i < 80 && rx_n < b + 6; i++) begin
            egress_tready = pat[i % 6];
            @(posedge clk);
            #1;
        end
        egress_tready = 1'b1;
        checks++;
        if (rx_n < b + 6) begin
            failures++;
            $display("FAIL bp_timeout beats=%0d required=6", rx_n - b);
        end
        for (int i = 0; i < 6; i++) begin
            checks++;
            if (rx_data[b+i] !== 16'h6000 + 16'(i) || rx_last[b+i] !== (i == 5)) begin
                failures++;
                $display("FAIL bp_beat%0d got=%h/%b required=%h/%b", i, rx_data[b+i], rx_last[b+i], 16'h6000 + 16'(i), i == 5);
            end
        end
        repeat (2) @(posedge clk);
        #1;
        track = 1'b0;
        checks++;
        if (ovf_err - o0 !== 0) begin
            failures++;
            $display("FAIL bp_overfill events=%0d required=0", ovf_err - o0);
        end
        checks++;
        if (stab_err - s0 !== 0) begin
            failures++;
            $display("FAIL bp_stability events=%0d required=0", stab_err - s0);
        end
    endtask

    task automatic test_fifo_empty;
        int b = rx_n;
        int r0 = nreads;
        push_word(16'h8000); push_word(16'h8001);
        push_desc(1'b0, 8);
        for (int i = 0; i < 30 && nreads < r0 + 2; i++) @(posedge clk);
        repeat (5) @(posedge clk);
        #1;
        for (int i = 2; i < 8; i++) push_word(16'h8000 + 16'(i));
        wait_rx(b + 8, 60, "fifo_empty");
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (rx_data[b+i] !== 16'h8000 + 16'(i) || rx_last[b+i] !== (i == 7)) begin
                failures++;
                $display("FAIL fe_beat%0d got=%h/%b required=%h/%b", i, rx_data[b+i], rx_last[b+i], 16'h8000 + 16'(i), i == 7);
            end
        end
        checks++;
        if (rx_cyc[b+2] - rx_cyc[b+1] < 5) begin
            failures++;
            $display("FAIL fe_stall gap=%0d required>=5", rx_cyc[b+2] - rx_cyc[b+1]);
        end
    endtask

    task automatic test_zero_len;
        int b = rx_n;
        int r0 = nreads;
`ifdef EGRESS_FRAME_STATS_EN
        logic [15:0] d0 = frames_dropped;
`endif
        push_word(16'hDEAD);
        push_desc(1'b0, 0);
        repeat (6) @(posedge clk);
        #1;
        checks++;
        if (nreads - r0 !== 0 || rx_n !== b) begin
            failures++;
            $display("FAIL zero_len_activity reads=%0d beats=%0d required=0,0", nreads - r0, rx_n - b);
        end
        checks++;
        if (busy_fall - sb_cyc !== 2) begin
            failures++;
            $display("FAIL zero_len_idle got=%0d required=2", busy_fall - sb_cyc);
        end
`ifdef EGRESS_FRAME_STATS_EN
        checks++;
        if (frames_dropped - d0 !== 16'd1) begin
            failures++;
            $display("FAIL zero_len_stats dropped=%0d required=1", frames_dropped - d0);
        end
`endif
        fifo_clr = 1'b1;
        @(posedge clk);
        #1;
        fifo_clr = 1'b0;
    endtask

    task automatic test_reset_mid;
        int b = rx_n;
        for (int i = 0; i < 5; i++) push_word(16'h9000 + 16'(i));
        push_desc(1'b0, 5);
        push_desc(1'b0, 2);
        wait_rx(b + 2, 40, "reset_mid");
        checks++;
        if (egress_tvalid !== 1'b1 || egress_tdata !== 16'h9002) begin
            failures++;
            $display("FAIL rm_third_beat got=%b/%h required=1/9002", egress_tvalid, egress_tdata);
        end
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if ({egress_tvalid, egress_tlast, busy, sb_ren, frame_ren} !== 5'd0) begin
            failures++;
            $display("FAIL rm_async_outputs got=%b required=00000", {egress_tvalid, egress_tlast, busy, sb_ren, frame_ren});
        end
        @(posedge clk);
        #1;
        fifo_clr = 1'b1;
        @(posedge clk);
        #1;
        fifo_clr = 1'b0;
        push_word(16'hAAA1);
        push_word(16'hAAA2);
        reset = 1'b0;
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL rm_idle_after busy=%b required=0", busy);
        end
        wait_rx(b + 4, 40, "reset_mid_next");
        checks++;
        if (rx_data[b+2] !== 16'hAAA1 || rx_last[b+2] !== 1'b0 || rx_data[b+3] !== 16'hAAA2 || rx_last[b+3] !== 1'b1) begin
            failures++;
            $display("FAIL rm_next_frame got=%h/%b %h/%b required=aaa1/0 aaa2/1", rx_data[b+2], rx_last[b+2], rx_data[b+3], rx_last[b+3]);
        end
`ifdef EGRESS_FRAME_STATS_EN
        checks++;
        if (frames_sent !== 16'd1) begin
            failures++;
            $display("FAIL rm_stats sent=%0d required=1", frames_sent);
        end
`endif
    endtask

    initial begin
        test_reset;
        test_basic;
        test_drop;
        test_backpressure;
        test_fifo_empty;
        test_zero_len;
        test_reset_mid;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog checks=%0d failures=%0d", checks, failures);
        $fatal(1);
    end
endmodule
